// File: rtl/hazard_ctrl_if.sv
// hazard_ctrl_if: ID-stage operand/destination info in, interlock and forwarding controls out
interface hazard_ctrl_if #(
    parameter int REG_AW = 3,
    parameter int CNT_W  = 16
);
    logic              id_valid;
    logic [REG_AW-1:0] id_rs;
    logic              id_rs_used;
    logic [REG_AW-1:0] id_rt;
    logic              id_rt_used;
    logic              id_wr_en;
    logic [REG_AW-1:0] id_rd;
    logic              id_is_load;
    logic              ex_redirect;
    logic              stall;
    logic              bubble;
    logic              flush;
    logic [1:0]        fwd_a;
    logic [1:0]        fwd_b;
    logic [CNT_W-1:0]  stall_cnt;

    modport master (
        output id_valid, id_rs, id_rs_used, id_rt, id_rt_used, id_wr_en, id_rd, id_is_load, ex_redirect,
        input  stall, bubble, flush, fwd_a, fwd_b, stall_cnt
    );

    modport slave (
        input  id_valid, id_rs, id_rs_used, id_rt, id_rt_used, id_wr_en, id_rd, id_is_load, ex_redirect,
        output stall, bubble, flush, fwd_a, fwd_b, stall_cnt
    );
endinterface

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: load-use interlock, EX operand forwarding selects and redirect squash for the 5-stage core
module hazard_ctrl #(
    parameter int REG_AW       = 3,
    parameter int FLUSH_CYCLES = 2,
    parameter int CNT_W        = 16
) (
    input logic         clk,
    input logic         rst,
    hazard_ctrl_if.slave hc
);
    typedef enum logic {RUN, FLUSH} state_t;

    state_t            state;
    logic [2:0]        cnt;
    logic              ex_v, ex_wr, ex_ld, ma_v, ma_wr;
    logic [REG_AW-1:0] ex_rd, ma_rd;
    logic              ex_w, ma_w, hz, issue;

    // Older writers in WB need no forwarding: the regfile write lands before the consumer reads
    function automatic logic [1:0] sel(input logic [REG_AW-1:0] r);
        return (ex_w & !ex_ld & ex_rd == r) ? 2'b01 : (ma_w & ma_rd == r) ? 2'b10 : 2'b00;
    endfunction

    // Interlock decisions; flush overrides a load-use stall and squashes the ID instruction
    always_comb begin
        ex_w      = ex_v & ex_wr & (ex_rd != '0);
        ma_w      = ma_v & ma_wr & (ma_rd != '0);
        hz        = hc.id_valid & ex_w & ex_ld &
                    ((hc.id_rs_used & hc.id_rs == ex_rd) | (hc.id_rt_used & hc.id_rt == ex_rd));
        hc.flush  = !rst & (state == FLUSH | hc.ex_redirect);
        hc.stall  = !rst & hz & !hc.flush;
        hc.bubble = hc.stall;
        issue     = hc.id_valid & !hc.stall & !hc.flush;
    end

    // Scoreboard shift and forwarding selects registered for the consumer's EX cycle
    always_ff @(posedge clk) begin
        if (rst) begin
            ex_v <= 1'b0; ex_wr <= 1'b0; ex_ld <= 1'b0; ex_rd <= '0;
            ma_v <= 1'b0; ma_wr <= 1'b0; ma_rd <= '0;
            hc.fwd_a <= 2'b00;
            hc.fwd_b <= 2'b00;
        end else begin
            ex_v <= issue; ex_wr <= hc.id_wr_en; ex_ld <= hc.id_is_load; ex_rd <= hc.id_rd;
            ma_v <= ex_v; ma_wr <= ex_wr; ma_rd <= ex_rd;
            hc.fwd_a <= issue ? sel(hc.id_rs) : 2'b00;
            hc.fwd_b <= issue ? sel(hc.id_rt) : 2'b00;
        end
    end

    // Saturating count of load-use stall cycles
    always_ff @(posedge clk) begin
        if (rst)
            hc.stall_cnt <= '0;
        else if (hc.stall & ~&hc.stall_cnt)
            hc.stall_cnt <= hc.stall_cnt + 1'b1;
    end

    // Redirect FSM: holds flush for the cycles after the redirect cycle itself
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= RUN;
            cnt   <= 3'd0;
        end else if (state == RUN) begin
            if (hc.ex_redirect && FLUSH_CYCLES > 1) begin
                state <= FLUSH;
                cnt   <= 3'(FLUSH_CYCLES - 2);
            end
        end else if (cnt == 3'd0) begin
            state <= RUN;
        end else begin
            cnt <= cnt - 3'd1;
        end
    end
endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl: directed and randomized checks of hazard_ctrl against an instruction-history model
module tb_hazard_ctrl;
    localparam int FC   = 2;
    localparam int CW   = 8;
    localparam int CMAX = (1 << CW) - 1;

    typedef struct packed {logic v; logic wr; logic ld; logic [2:0] rd;} ins_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_vec = 0;
    int   n_err = 0;

    ins_t hist[$];
    int   flush_left, m_cnt, m_fa, m_fb;
    bit   e_stall, e_flush;

    hazard_ctrl_if #(.REG_AW(3), .CNT_W(CW)) hc();
    hazard_ctrl #(.REG_AW(3), .FLUSH_CYCLES(FC), .CNT_W(CW)) dut (.clk(clk), .rst(rst), .hc(hc));

    always #5 clk = ~clk;

    function automatic bit writes(ins_t i, logic [2:0] r);
        return i.v && i.wr && i.rd != 3'd0 && i.rd == r;
    endfunction

    function automatic int fsel(logic [2:0] r);
        if (writes(hist[0], r) && !hist[0].ld) return 1;
        if (writes(hist[1], r)) return 2;
        return 0;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        hist = {ins_t'(0), ins_t'(0)};
        flush_left = 0;
        m_cnt = 0;
        m_fa = 0;
        m_fb = 0;
    endtask

    task automatic model_eval_compare();
        ins_t e = hist[0];
        bit uses_e = (hc.id_rs_used && hc.id_rs == e.rd) || (hc.id_rt_used && hc.id_rt == e.rd);
        bit hz = hc.id_valid && e.ld && writes(e, e.rd) && uses_e;
        e_flush = !rst && (flush_left > 0 || hc.ex_redirect);
        e_stall = !rst && hz && !e_flush;
        chk("stall", hc.stall, e_stall);
        chk("bubble", hc.bubble, e_stall);
        chk("flush", hc.flush, e_flush);
        chk("fwd_a", hc.fwd_a, m_fa);
        chk("fwd_b", hc.fwd_b, m_fb);
        chk("stall_cnt", hc.stall_cnt, m_cnt);
    endtask

    task automatic model_update();
        bit issue;
        ins_t n;
        if (rst) begin
            model_reset();
            return;
        end
        issue = hc.id_valid && !e_stall && !e_flush;
        m_fa = issue ? fsel(hc.id_rs) : 0;
        m_fb = issue ? fsel(hc.id_rt) : 0;
        if (e_stall && m_cnt < CMAX) m_cnt++;
        if (flush_left > 0) flush_left--;
        else if (hc.ex_redirect) flush_left = FC - 1;
        n = '0;
        if (issue) begin
            n.v = 1'b1; n.wr = hc.id_wr_en; n.ld = hc.id_is_load; n.rd = hc.id_rd;
        end
        hist.push_front(n);
        void'(hist.pop_back());
    endtask

    task automatic cyc(input bit v, input int rs, input bit rsu, input int rt, input bit rtu,
                       input bit wr, input int rd, input bit ld, input bit redir, input bit r);
        hc.id_valid = v; hc.id_rs = 3'(rs); hc.id_rs_used = rsu; hc.id_rt = 3'(rt); hc.id_rt_used = rtu;
        hc.id_wr_en = wr; hc.id_rd = 3'(rd); hc.id_is_load = ld; hc.ex_redirect = redir; rst = r;
        #1;
        model_eval_compare();
    endtask

    task automatic adv();
        @(posedge clk);
        model_update();
        @(negedge clk);
    endtask

    task automatic idle(input bit redir, input bit r);
        cyc(0, 0, 0, 0, 0, 0, 0, 0, redir, r);
    endtask

    task automatic lu_pair();
        cyc(1, 0, 0, 0, 0, 1, 3, 1, 0, 0); adv();
        cyc(1, 3, 1, 1, 1, 1, 4, 0, 0, 0); adv();
        cyc(1, 3, 1, 1, 1, 1, 4, 0, 0, 0); adv();
    endtask

    initial begin
        hc.id_valid = 0; hc.id_rs = 0; hc.id_rs_used = 0; hc.id_rt = 0; hc.id_rt_used = 0;
        hc.id_wr_en = 0; hc.id_rd = 0; hc.id_is_load = 0; hc.ex_redirect = 0;
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);

        idle(0, 0);
        chk("rst_flush", hc.flush, 0);
        chk("rst_fwd_a", hc.fwd_a, 0);
        chk("rst_cnt", hc.stall_cnt, 0);
        adv();

        cyc(1, 0, 0, 0, 0, 1, 3, 1, 0, 0); adv();
        cyc(1, 3, 1, 1, 1, 1, 4, 0, 0, 0);
        chk("lu_stall", hc.stall, 1);
        chk("lu_bubble", hc.bubble, 1);
        adv();
        cyc(1, 3, 1, 1, 1, 1, 4, 0, 0, 0);
        chk("lu_stall_once", hc.stall, 0);
        adv();
        idle(0, 0);
        chk("lu_fwd_a", hc.fwd_a, 2);
        chk("lu_fwd_b", hc.fwd_b, 0);
        chk("lu_cnt", hc.stall_cnt, 1);
        adv();

        repeat (4) lu_pair();
        idle(1, 0);
        chk("redir_flush", hc.flush, 1);
        adv();
        idle(0, 1);
        chk("inflush_cnt", hc.stall_cnt, 5);
        chk("rst_kills_flush", hc.flush, 0);
        adv();
        idle(0, 1); adv();
        idle(0, 0);
        chk("post_rst_flush", hc.flush, 0);
        chk("post_rst_stall", hc.stall, 0);
        chk("post_rst_fwd_a", hc.fwd_a, 0);
        chk("post_rst_fwd_b", hc.fwd_b, 0);
        chk("post_rst_cnt", hc.stall_cnt, 0);
        adv();

        cyc(1, 1, 1, 0, 0, 1, 2, 0, 0, 0); adv();
        cyc(1, 2, 1, 2, 1, 1, 4, 0, 0, 0);
        chk("alu_nostall", hc.stall, 0);
        adv();
        cyc(1, 2, 1, 0, 1, 1, 5, 0, 0, 0);
        chk("alu_fwd_a", hc.fwd_a, 1);
        chk("alu_fwd_b", hc.fwd_b, 1);
        adv();
        idle(0, 0);
        chk("third_fwd_a", hc.fwd_a, 2);
        chk("third_fwd_b", hc.fwd_b, 0);
        adv();

        cyc(1, 0, 0, 0, 0, 1, 0, 1, 0, 0); adv();
        cyc(1, 0, 1, 0, 1, 1, 4, 0, 0, 0);
        chk("r0_nostall", hc.stall, 0);
        adv();
        idle(0, 0);
        chk("r0_fwd_a", hc.fwd_a, 0);
        chk("r0_fwd_b", hc.fwd_b, 0);
        adv();

        idle(1, 0);
        chk("fl_t0", hc.flush, 1);
        adv();
        idle(1, 0);
        chk("fl_t1", hc.flush, 1);
        adv();
        idle(0, 0);
        chk("fl_t2", hc.flush, 0);
        adv();

        cyc(1, 0, 0, 0, 0, 1, 3, 1, 0, 0); adv();
        cyc(1, 3, 1, 1, 1, 1, 4, 0, 1, 0);
        chk("both_stall", hc.stall, 0);
        chk("both_flush", hc.flush, 1);
        adv();
        idle(0, 0);
        chk("both_cnt", hc.stall_cnt, 0);
        chk("squash_fwd_a", hc.fwd_a, 0);
        adv();
        idle(0, 0); adv();

        repeat (CMAX + 10) lu_pair();
        idle(0, 0);
        chk("sat_cnt", hc.stall_cnt, CMAX);
        adv();

        idle(0, 1); adv();
        for (int i = 0; i < 3000; i++) begin
            cyc($urandom_range(0, 3) != 0, $urandom_range(0, 4), $urandom_range(0, 1) == 1,
                $urandom_range(0, 4), $urandom_range(0, 1) == 1, $urandom_range(0, 3) != 0,
                $urandom_range(0, 4), $urandom_range(0, 2) == 0, $urandom_range(0, 9) == 0,
                $urandom_range(0, 149) == 0);
            adv();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
